alu_result_stage: RTL and testbench

- Registered stage directly downstream of the ALU result multiplexer.
- Captures the selected N-bit result and opcode, generates NZCV status flags, and buffers up to 2 results in a skid buffer with valid/ready on both sides.
- Feeds the register-file write-back and flag-register logic, and decouples ALU timing from the consumer.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_flag_gen.sv | 28 ++
 rtl/alu_result_stage.sv | 122 ++++++++++++
 tb/tb_alu_result_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, NZCV flag bit positions and the result-stage buffer entry.
`default_nettype none

package alu_pkg;

   localparam int ALU_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_INV = 3'd7
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int BUF_DEPTH = 2;

   typedef struct packed {
      logic [ALU_W-1:0] result;
      alu_op_e          op;
      logic [3:0]       flags;
   } alu_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation for a result-mux output; C and V pass through only for ADD/SUB.
`default_nettype none

module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int N = ALU_W
) (
   input  logic [N-1:0] in_result,
   input  alu_op_e      in_op,
   input  logic         in_carry,
   input  logic         in_ovf,
   output logic [3:0]   flags
);

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = in_result[N-1];
      flags[FLAG_Z] = (in_result == '0);
      if ((in_op == OP_ADD) || (in_op == OP_SUB)) begin
         flags[FLAG_C] = in_carry;
         flags[FLAG_V] = in_ovf;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer with NZCV flags and sticky invalid-opcode error.
// Optional macro ALU_RESULT_COUNT_EN adds a 16-bit wrapping pop counter (xfer_count).
`default_nettype none

module alu_result_stage
   import alu_pkg::*;
#(
   parameter int N = ALU_W   // must equal ALU_W, the width of the shared entry struct
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_result,
   input  logic [2:0]   in_op,
   input  logic         in_carry,
   input  logic         in_ovf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [3:0]   out_flags,
   output logic [2:0]   out_op,
   output logic         err_op
`ifdef ALU_RESULT_COUNT_EN
   ,
   output logic [15:0]  xfer_count
`endif
);

   logic [1:0] count_q, count_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       err_q, err_d;
   alu_entry_t mem_q [BUF_DEPTH];
   alu_entry_t mem_d [BUF_DEPTH];
   alu_entry_t head_q, head_d;
   alu_entry_t new_entry;
   logic [3:0] new_flags;
   logic       push, pop;

   alu_flag_gen #(.N(N)) u_flag_gen (
      .in_result (in_result),
      .in_op     (alu_op_e'(in_op)),
      .in_carry  (in_carry),
      .in_ovf    (in_ovf),
      .flags     (new_flags)
   );

   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign new_entry = '{result: in_result, op: alu_op_e'(in_op), flags: new_flags};

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
         wr_ptr_d        = ~wr_ptr_q;
         if (in_op == OP_INV) begin
            err_d = 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      // Output register mirrors the next head so data is visible the cycle after the push,
      // and keeps its last value once the buffer drains.
      head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         err_q    <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
         mem_q    <= mem_d;
         head_q   <= head_d;
      end
   end

   assign out_result = head_q.result;
   assign out_flags  = head_q.flags;
   assign out_op     = head_q.op;
   assign err_op     = err_q;

`ifdef ALU_RESULT_COUNT_EN
   logic [15:0] xfer_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_q <= '0;
      end else if (pop) begin
         xfer_q <= xfer_q + 16'd1;
      end
   end

   assign xfer_count = xfer_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table plus backpressure, streaming, error and reset sequences.
`default_nettype none

module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_result;
   logic [2:0] in_op;
   logic       in_carry;
   logic       in_ovf;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic [3:0] out_flags;
   logic [2:0] out_op;
   logic       err_op;
`ifdef ALU_RESULT_COUNT_EN
   logic [15:0] xfer_count;
`endif

   int total = 0;
   int bad   = 0;
   int exp_xfer = 0;

   alu_result_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_op      (in_op),
      .in_carry   (in_carry),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_op     (out_op),
      .err_op     (err_op)
`ifdef ALU_RESULT_COUNT_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] res;
      logic [2:0] op;
      logic       c;
      logic       v;
      logic [3:0] flags;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      logic pop_now;
      pop_now = out_valid & out_ready;
      @(posedge clk);
      if (pop_now && rst_n) exp_xfer++;
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] r, input logic [2:0] op,
                        input logic c, input logic o, input logic rdy);
      in_valid  = v;
      in_result = r;
      in_op     = op;
      in_carry  = c;
      in_ovf    = o;
      out_ready = rdy;
   endtask

   task automatic check_xfer(input string name);
`ifdef ALU_RESULT_COUNT_EN
      check(name, {16'd0, xfer_count}, {16'd0, exp_xfer[15:0]});
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   initial begin
      vecs[0] = '{4'h0, 3'd0, 1'b1, 1'b0, 4'b0110};
      vecs[1] = '{4'h8, 3'd1, 1'b0, 1'b1, 4'b1001};
      vecs[2] = '{4'h3, 3'd2, 1'b1, 1'b1, 4'b0000};
      vecs[3] = '{4'hF, 3'd3, 1'b1, 1'b0, 4'b1000};
      vecs[4] = '{4'h0, 3'd4, 1'b0, 1'b1, 4'b0100};
      vecs[5] = '{4'h9, 3'd5, 1'b1, 1'b1, 4'b1000};
      vecs[6] = '{4'h7, 3'd6, 1'b1, 1'b0, 4'b0000};
      vecs[7] = '{4'h5, 3'd1, 1'b1, 1'b1, 4'b0011};
      vecs[8] = '{4'hC, 3'd0, 1'b1, 1'b1, 4'b1011};

      drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", {28'd0, out_result}, 32'd0);
      check("rst_out_flags", {28'd0, out_flags}, 32'd0);
      check("rst_out_op", {29'd0, out_op}, 32'd0);
      check("rst_err_op", {31'd0, err_op}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_xfer("rst_xfer");

      // Flag table: push into empty buffer, check head, pop, check hold.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].res, vecs[i].op, vecs[i].c, vecs[i].v, 1'b0);
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_result", i), {28'd0, out_result}, {28'd0, vecs[i].res});
         check($sformatf("vec%0d_flags", i), {28'd0, out_flags}, {28'd0, vecs[i].flags});
         check($sformatf("vec%0d_op", i), {29'd0, out_op}, {29'd0, vecs[i].op});
         check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
         check($sformatf("vec%0d_hold", i), {28'd0, out_result}, {28'd0, vecs[i].res});
      end
      check("table_err_clear", {31'd0, err_op}, 32'd0);

      // Backpressure: fill both slots, third offer ignored, drain in order.
      drive(1'b1, 4'h8, 3'd1, 1'b0, 1'b1, 1'b0);
      step();
      check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 4'h3, 3'd2, 1'b1, 1'b0, 1'b0);
      step();
      check("bp_ready_full", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 4'h5, 3'd7, 1'b1, 1'b1, 1'b0);
      step();
      check("bp_ready_still_full", {31'd0, in_ready}, 32'd0);
      check("bp_head_kept", {28'd0, out_result}, 32'h8);
      check("bp_err_ignored", {31'd0, err_op}, 32'd0);
      drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      check("bp_pop1_result", {28'd0, out_result}, 32'h8);
      check("bp_pop1_flags", {28'd0, out_flags}, 32'b1001);
      step();
      check("bp_pop2_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pop2_result", {28'd0, out_result}, 32'h3);
      check("bp_pop2_flags", {28'd0, out_flags}, 32'b0000);
      check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      check_xfer("bp_xfer");

      // Streaming: one in, one out per cycle, never more than one held.
      for (int i = 0; i < 20; i++) begin
         logic [4:0] iv;
         iv = 5'(i);
         drive(1'b1, iv[3:0], 3'd0, 1'b0, 1'b0, 1'b1);
         step();
         check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("stream%0d_result", i), {28'd0, out_result}, {28'd0, iv[3:0]});
         check($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", {31'd0, out_valid}, 32'd0);
      check_xfer("stream_xfer");

      // Simultaneous push/pop at count 1.
      drive(1'b1, 4'hA, 3'd3, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'h6, 3'd4, 1'b0, 1'b0, 1'b1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("simul_valid", {31'd0, out_valid}, 32'd1);
      check("simul_head", {28'd0, out_result}, 32'h6);
      check("simul_op", {29'd0, out_op}, 32'd4);
      check("simul_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("simul_single", {31'd0, out_valid}, 32'd0);

      // Invalid opcode: sticky error.
      drive(1'b1, 4'h0, 3'd7, 1'b1, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      check("inv_flags", {28'd0, out_flags}, 32'b0100);
      check("inv_op", {29'd0, out_op}, 32'd7);
      check("inv_err", {31'd0, err_op}, 32'd1);
      drive(1'b1, 4'h1, 3'd0, 1'b0, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      check("inv_err_sticky", {31'd0, err_op}, 32'd1);
      out_ready = 1'b0;

      // Async reset with two entries held.
      drive(1'b1, 4'h9, 3'd0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'h2, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      check("prerst_full", {31'd0, in_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_err", {31'd0, err_op}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_result", {28'd0, out_result}, 32'd0);
      exp_xfer = 0;
      check_xfer("arst_xfer");
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("postrst_empty", {31'd0, out_valid}, 32'd0);

`ifdef ALU_RESULT_COUNT_EN
      // Counter wrap: 65536 pops bring it back to zero.
      drive(1'b1, 4'h1, 3'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 65537; i++) begin
         step();
      end
      in_valid = 1'b0;
      check_xfer("xfer_wrap");
      step();
      check_xfer("xfer_after_wrap");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
